// File: rtl/cpu_stage_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with a memory-wait watchdog and a retired-instruction counter.
// Strobes are decoded from the current state and latched opcode, plus the memory ready inputs.
module cpu_stage_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             dmem_re,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             wb_sel,
   output logic             illegal_op,
   output logic             mem_err,
   output logic [CNT_W-1:0] retired
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        op_q;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              mem_err_q;
   logic [CNT_W-1:0]  retired_q;
   logic              set_err;
   logic              at_limit;
   logic              is_load, is_store, is_wb_op;
   logic              imem_req_c, ir_we_c, pc_we_c, dmem_re_c, dmem_we_c;
   logic              rf_we_c, wb_sel_c, illegal_c;

   function automatic logic writes_back(input logic [6:0] op);
      return (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) ||
             (op == OPC_JALR) || (op == OPC_OPIMM) || (op == OPC_OP);
   endfunction

   assign is_load  = (op_q == OPC_LOAD);
   assign is_store = (op_q == OPC_STORE);
   assign is_wb_op = writes_back(op_q);
   assign at_limit = (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));

   // wait_cnt_d defaults to zero, so it is cleared on entry to every waiting state
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      set_err    = 1'b0;
      imem_req_c = 1'b0;
      ir_we_c    = 1'b0;
      pc_we_c    = 1'b0;
      dmem_re_c  = 1'b0;
      dmem_we_c  = 1'b0;
      rf_we_c    = 1'b0;
      wb_sel_c   = 1'b0;
      illegal_c  = 1'b0;
      case (state_q)
         S_IF: begin
            if (imem_ready) begin
               imem_req_c = 1'b1;
               ir_we_c    = 1'b1;
               state_d    = S_ID;
            end else if (at_limit) begin
               state_d = S_HALT;
               set_err = 1'b1;
            end else begin
               imem_req_c = 1'b1;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_ID: state_d = S_EX;
         S_EX: begin
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_wb_op) begin
               state_d = S_WB;
            end else begin
               pc_we_c   = 1'b1;
               illegal_c = (op_q != OPC_BRANCH);
               state_d   = S_IF;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               dmem_re_c = is_load;
               dmem_we_c = is_store;
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  pc_we_c = 1'b1;
                  state_d = S_IF;
               end
            end else if (at_limit) begin
               state_d = S_HALT;
               set_err = 1'b1;
            end else begin
               dmem_re_c  = is_load;
               dmem_we_c  = is_store;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_WB: begin
            rf_we_c  = 1'b1;
            pc_we_c  = 1'b1;
            wb_sel_c = is_load;
            state_d  = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IF;
         op_q       <= '0;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (state_q == S_ID) op_q <= opcode;
         if (set_err) mem_err_q <= 1'b1;
         if (pc_we_c) retired_q <= retired_q + 1'b1;
      end
   end

   // Reset forces every output low in the same cycle, independent of the registered state
   assign imem_req   = imem_req_c & ~rst;
   assign ir_we      = ir_we_c    & ~rst;
   assign pc_we      = pc_we_c    & ~rst;
   assign dmem_re    = dmem_re_c  & ~rst;
   assign dmem_we    = dmem_we_c  & ~rst;
   assign rf_we      = rf_we_c    & ~rst;
   assign wb_sel     = wb_sel_c   & ~rst;
   assign illegal_op = illegal_c  & ~rst;
   assign mem_err    = mem_err_q  & ~rst;
   assign retired    = rst ? '0 : retired_q;

endmodule
